enc_mask_seq: RTL and testbench

Sequential, parametrised GF(2) codeword encoder: computes `out = r·M` (encode mode) or `out = x ⊕ r·M` (mask mode). `r` is a D-bit random vector and `M` is a D×(8+D) generator matrix held in an internal, host-loadable row bank. The block processes LANES matrix rows per cycle behind valid/ready handshakes. It sits between the randomness source and the CLM datapath, and supplies fresh encoded masks or re-masks existing codewords.

---
 rtl/enc_mask_seq.sv | 132 +++++++++++++
 tb/tb_enc_mask_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/enc_mask_seq.sv
// enc_mask_seq: sequential GF(2) codeword encoder / re-masker.
//   encode (mode=0): out = r*M
//   mask   (mode=1): out = x ^ r*M
// M is a D x N row bank loaded through m_we/m_idx/m_row; LANES rows are
// folded into the accumulator per RUN cycle.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   m_we, m_idx, m_row    matrix row write (row m_idx <= m_row)
//   m_drop                registered pulse: previous-cycle write ignored
//   in_valid, in_ready    request handshake (mode, r, x)
//   out_valid, out_ready  result handshake (out)
//   busy                  high while rows are being accumulated
module enc_mask_seq #(
   parameter int unsigned D     = 8,
   parameter int unsigned N     = 8 + D,
   parameter int unsigned LANES = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               m_we,
   input  logic [((D > 1) ? $clog2(D) : 1)-1:0] m_idx,
   input  logic [N-1:0]                       m_row,
   output logic                               m_drop,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic                               mode,
   input  logic [D-1:0]                       r,
   input  logic [N-1:0]                       x,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [N-1:0]                       out,
   output logic                               busy
);

   localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;
   localparam int unsigned CW = $clog2(D + 1);

   // Elaboration-time parameter sanity.
   if (D < 1 || LANES < 1 || (D % LANES) != 0) begin : g_param_check
      $error("enc_mask_seq: D must be >= 1 and divisible by LANES");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   acc_q,   acc_d;
   logic [CW-1:0]  cnt_q,   cnt_d;
   logic [D-1:0]   r_q,     r_d;
   logic [N-1:0]   m_q [D];
   logic [N-1:0]   m_d [D];
   logic           m_drop_q, m_drop_d;
   logic           idx_ok;
   logic           wr_ok;

   // Row index range check; a power-of-two D makes every index legal.
   assign idx_ok = ({1'b0, m_idx} < (IW + 1)'(D));
   assign wr_ok  = m_we && idx_ok && (state_q != S_RUN);

   // Next-state, accumulator and row-bank update.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      r_d      = r_q;
      m_d      = m_q;
      m_drop_d = m_we && !wr_ok;

      if (wr_ok) begin
         m_d[m_idx] = m_row;
      end

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_RUN;
               r_d     = r;
               acc_d   = mode ? x : '0;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            // Fold rows cnt .. cnt+LANES-1 selected by the latched r.
            for (int j = 0; j < int'(D); j++) begin
               if ((j >= int'(cnt_q)) && (j < int'(cnt_q) + int'(LANES)) && r_q[j]) begin
                  acc_d = acc_d ^ m_q[j];
               end
            end
            cnt_d = cnt_q + CW'(LANES);
            if (cnt_q == CW'(D - LANES)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register; reset discards any in-flight request and clears M.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         r_q      <= '0;
         m_q      <= '{default: '0};
         m_drop_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         r_q      <= r_d;
         m_q      <= m_d;
         m_drop_q <= m_drop_d;
      end
   end

   // in_ready is a pure state decode, gated low while reset is held.
   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_RUN);
   assign out       = acc_q;
   assign m_drop    = m_drop_q;

endmodule

// File: tb/tb_enc_mask_seq.sv
// Directed bench for enc_mask_seq: u0 (D=8, LANES=1), u1 (D=8, LANES=2),
// u2 (D=6, LANES=1) for the out-of-range row index case.
module tb_enc_mask_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        m_we;
   logic [2:0]  m_idx;
   logic [15:0] m_row;
   logic        mode;
   logic [7:0]  r;
   logic [15:0] x;
   logic        iv0, iv1, iv2;
   logic        ordy0, ordy1, ordy2;

   logic        m_drop0, in_ready0, out_valid0, busy0;
   logic [15:0] out0;
   logic        m_drop1, in_ready1, out_valid1, busy1;
   logic [15:0] out1;
   logic        m_drop2, in_ready2, out_valid2, busy2;
   logic [13:0] out2;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int t_acc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   enc_mask_seq #(.D(8), .LANES(1)) u0 (
      .clk(clk), .rst(rst), .m_we(m_we), .m_idx(m_idx), .m_row(m_row), .m_drop(m_drop0),
      .in_valid(iv0), .in_ready(in_ready0), .mode(mode), .r(r), .x(x),
      .out_valid(out_valid0), .out_ready(ordy0), .out(out0), .busy(busy0));

   enc_mask_seq #(.D(8), .LANES(2)) u1 (
      .clk(clk), .rst(rst), .m_we(m_we), .m_idx(m_idx), .m_row(m_row), .m_drop(m_drop1),
      .in_valid(iv1), .in_ready(in_ready1), .mode(mode), .r(r), .x(x),
      .out_valid(out_valid1), .out_ready(ordy1), .out(out1), .busy(busy1));

   enc_mask_seq #(.D(6), .LANES(1)) u2 (
      .clk(clk), .rst(rst), .m_we(m_we), .m_idx(m_idx), .m_row(m_row[13:0]), .m_drop(m_drop2),
      .in_valid(iv2), .in_ready(in_ready2), .mode(mode), .r(r[5:0]), .x(x[13:0]),
      .out_valid(out_valid2), .out_ready(ordy2), .out(out2), .busy(busy2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] idx, input logic [15:0] row);
      m_we  = 1'b1;
      m_idx = idx;
      m_row = row;
      tick();
      m_we  = 1'b0;
   endtask

   task automatic start(input int sel, input logic md, input logic [7:0] rv, input logic [15:0] xv);
      chk("in_ready_before_req", (sel == 0) ? in_ready0 : in_ready1, 1);
      mode = md;
      r    = rv;
      x    = xv;
      if (sel == 0) iv0 = 1'b1;
      else          iv1 = 1'b1;
      tick();
      iv0   = 1'b0;
      iv1   = 1'b0;
      t_acc = cyc;
   endtask

   task automatic wait_done(input int sel, input int exp_lat, input logic [15:0] exp_out, input string tag);
      int guard = 0;
      while (((sel == 0) ? out_valid0 : out_valid1) !== 1'b1 && guard < 50) begin
         tick();
         guard++;
      end
      chk({tag, "_latency"}, cyc - t_acc, exp_lat);
      chk({tag, "_out"}, (sel == 0) ? out0 : out1, exp_out);
   endtask

   task automatic ack(input int sel);
      if (sel == 0) ordy0 = 1'b1;
      else          ordy1 = 1'b1;
      tick();
      ordy0 = 1'b0;
      ordy1 = 1'b0;
      chk("ack_out_valid_low", (sel == 0) ? out_valid0 : out_valid1, 0);
      chk("ack_in_ready_high", (sel == 0) ? in_ready0 : in_ready1, 1);
   endtask

   initial begin
      rst = 1'b1; m_we = 1'b0; m_idx = '0; m_row = '0;
      mode = 1'b0; r = '0; x = '0;
      iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
      ordy0 = 1'b0; ordy1 = 1'b0; ordy2 = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_in_ready", in_ready0, 0);
      chk("rst_out_valid", out_valid0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_m_drop", m_drop0, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready0, 1);
      tick();

      // Identity rows M[j] = 1<<j
      for (int j = 0; j < 8; j++) wr(3'(j), 16'h0001 << j);
      chk("legal_write_no_drop", m_drop0, 0);

      // Encode
      start(0, 1'b0, 8'hA5, 16'h1234);
      chk("run_busy", busy0, 1);
      chk("run_in_ready", in_ready0, 0);
      wait_done(0, 8, 16'h00A5, "encode_a5");
      ack(0);

      // Mask
      start(0, 1'b1, 8'h0F, 16'hFFFF);
      wait_done(0, 8, 16'hFFF0, "mask_0f");
      ack(0);
      start(0, 1'b1, 8'h00, 16'hFFFF);
      wait_done(0, 8, 16'hFFFF, "mask_00");
      ack(0);

      // Backpressure
      start(0, 1'b0, 8'hA5, 16'h0000);
      wait_done(0, 8, 16'h00A5, "bp");
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_stable", out0, 16'h00A5);
         chk("bp_out_valid", out_valid0, 1);
         chk("bp_in_ready", in_ready0, 0);
         tick();
      end
      ack(0);

      // Write during RUN is dropped; row 7 is consumed last so the old value must show
      start(0, 1'b0, 8'h80, 16'h0000);
      tick();
      wr(3'd7, 16'h0001);
      chk("run_write_drop", m_drop0, 1);
      tick();
      chk("run_write_drop_pulse_end", m_drop0, 0);
      wait_done(0, 8, 16'h0080, "run_write_old_row");
      ack(0);

      // Out-of-range index (6 on a D=6 block); same write is legal on u0
      wr(3'd6, 16'h0040);
      chk("oor_drop", m_drop2, 1);
      chk("in_range_no_drop", m_drop0, 0);
      tick();
      chk("oor_drop_pulse_end", m_drop2, 0);

      // Write in DONE is accepted and leaves out untouched
      start(0, 1'b0, 8'h03, 16'h0000);
      wait_done(0, 8, 16'h0003, "pre_done_write");
      wr(3'd0, 16'h0100);
      chk("done_write_no_drop", m_drop0, 0);
      chk("done_write_out_hold", out0, 16'h0003);
      chk("done_write_valid_hold", out_valid0, 1);
      ack(0);
      start(0, 1'b0, 8'h01, 16'h0000);
      wait_done(0, 8, 16'h0100, "done_write_used");
      ack(0);
      wr(3'd0, 16'h0001);

      // Reset mid-RUN
      start(0, 1'b0, 8'hFF, 16'h0000);
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("midrun_rst_out_valid", out_valid0, 0);
      chk("midrun_rst_busy", busy0, 0);
      chk("midrun_rst_in_ready", in_ready0, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrun_rst_release_ready", in_ready0, 1);
      tick();
      start(0, 1'b0, 8'hFF, 16'h0000);
      wait_done(0, 8, 16'h0000, "post_rst_cleared_m");
      ack(0);

      // Parity with LANES=2
      for (int j = 0; j < 8; j++) wr(3'(j), 16'hFFFF);
      start(1, 1'b0, 8'h07, 16'h0000);
      wait_done(1, 4, 16'hFFFF, "parity_07");
      ack(1);
      start(1, 1'b0, 8'h03, 16'h0000);
      wait_done(1, 4, 16'h0000, "parity_03");
      ack(1);
      start(1, 1'b1, 8'h01, 16'h1234);
      wait_done(1, 4, 16'hEDCB, "lanes2_mask");
      ack(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
